// File: rtl/accum_rr_arbiter.sv
// Two-requester round-robin front end for a shared N-bit add/subtract accumulator.
// Each operation takes IDLE -> EXEC -> ACK, with a registered one-cycle acknowledge.
module accum_rr_arbiter #(
  parameter int N = 8
) (
  input  logic         clk,
  input  logic         aclr,
  input  logic         req0,
  input  logic         req1,
  input  logic         sub0,
  input  logic         sub1,
  input  logic [N-1:0] data0,
  input  logic [N-1:0] data1,
  input  logic         clr,
  output logic         ack0,
  output logic         ack1,
  output logic [N-1:0] acc,
  output logic         carry,
  output logic         overflow,
  output logic         busy
);

  typedef enum logic [1:0] {IDLE, EXEC, ACK} state_t;

  state_t       state, state_nxt;
  logic         last;      // id of the last granted requester
  logic         grant, win;
  logic         win_id, op_sub;
  logic [N-1:0] op;
  logic [N:0]   res;
  logic         ovf;

  always_ff @(posedge clk) begin
    if (!aclr) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    grant     = 1'b0;
    // On a tie the requester not served last wins.
    win       = (req0 && req1) ? ~last : req1;
    case (state)
      IDLE: if (!clr && (req0 || req1)) begin
        grant     = 1'b1;
        state_nxt = EXEC;
      end
      EXEC:    state_nxt = ACK;
      ACK:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    res = op_sub ? ({1'b0, acc} - {1'b0, op}) : ({1'b0, acc} + {1'b0, op});
    if (op_sub) ovf = (acc[N-1] != op[N-1]) && (res[N-1] != acc[N-1]);
    else        ovf = (acc[N-1] == op[N-1]) && (res[N-1] != acc[N-1]);
  end

  always_ff @(posedge clk) begin
    if (!aclr) begin
      last     <= 1'b1;
      win_id   <= 1'b0;
      op_sub   <= 1'b0;
      op       <= '0;
      ack0     <= 1'b0;
      ack1     <= 1'b0;
      busy     <= 1'b0;
      acc      <= '0;
      carry    <= 1'b0;
      overflow <= 1'b0;
    end else begin
      if (grant) begin
        op     <= win ? data1 : data0;
        op_sub <= win ? sub1 : sub0;
        win_id <= win;
        last   <= win;
      end
      ack0 <= (state == EXEC) && !win_id;
      ack1 <= (state == EXEC) &&  win_id;
      busy <= (state_nxt != IDLE);
      // Clear beats a pending op; the ack still goes out from EXEC.
      if (clr) begin
        acc      <= '0;
        carry    <= 1'b0;
        overflow <= 1'b0;
      end else if (state == EXEC) begin
        acc      <= res[N-1:0];
        carry    <= res[N];
        overflow <= ovf;
      end
    end
  end

endmodule

// File: tb/tb_accum_rr_arbiter.sv
// Directed bench for accum_rr_arbiter: hand-computed accumulator, flag and ack timing vectors.
module tb_accum_rr_arbiter;
  localparam int N = 8;

  logic         clk = 1'b0;
  logic         aclr, req0, req1, sub0, sub1, clr;
  logic [N-1:0] data0, data1;
  logic         ack0, ack1, carry, overflow, busy;
  logic [N-1:0] acc;

  int checks = 0;
  int errors = 0;

  accum_rr_arbiter #(.N(N)) dut (
    .clk(clk), .aclr(aclr), .req0(req0), .req1(req1), .sub0(sub0), .sub1(sub1),
    .data0(data0), .data1(data1), .clr(clr), .ack0(ack0), .ack1(ack1),
    .acc(acc), .carry(carry), .overflow(overflow), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_res(input string tag, input logic [N-1:0] a, input logic c, input logic v);
    chk({tag, ".acc"}, 32'(acc), 32'(a));
    chk({tag, ".carry"}, 32'(carry), 32'(c));
    chk({tag, ".ovf"}, 32'(overflow), 32'(v));
  endtask

  // One full request from a single requester, checking the 3-cycle handshake.
  task automatic do_op(input string tag, input logic id, input logic s, input logic [N-1:0] d);
    if (id) begin req1 = 1'b1; sub1 = s; data1 = d; end
    else    begin req0 = 1'b1; sub0 = s; data0 = d; end
    tick();
    chk({tag, ".exec_busy"}, 32'(busy), 32'd1);
    chk({tag, ".exec_ack"}, 32'({ack1, ack0}), 32'd0);
    tick();
    chk({tag, ".ack"}, 32'({ack1, ack0}), id ? 32'd2 : 32'd1);
    req0 = 1'b0; req1 = 1'b0;
    tick();
    chk({tag, ".idle_ack"}, 32'({ack1, ack0}), 32'd0);
    chk({tag, ".idle_busy"}, 32'(busy), 32'd0);
  endtask

  task automatic do_clr();
    clr = 1'b1;
    tick();
    clr = 1'b0;
  endtask

  initial begin
    aclr = 1'b0; req0 = 1'b0; req1 = 1'b0; sub0 = 1'b0; sub1 = 1'b0;
    clr = 1'b0; data0 = '0; data1 = '0;
    tick(); tick();
    chk_res("rst", 8'h00, 1'b0, 1'b0);
    chk("rst.ack", 32'({ack1, ack0}), 32'd0);
    chk("rst.busy", 32'(busy), 32'd0);
    aclr = 1'b1;

    // single add
    do_op("add5", 1'b0, 1'b0, 8'h05);
    chk_res("add5", 8'h05, 1'b0, 1'b0);

    // both requesters continuously: pointer reset so 0 wins first
    aclr = 1'b0; tick(); aclr = 1'b1;
    req0 = 1'b1; req1 = 1'b1; sub0 = 1'b0; sub1 = 1'b0; data0 = 8'h01; data1 = 8'h02;
    for (int k = 1; k <= 11; k++) begin
      tick();
      if (k % 3 == 2) begin
        chk($sformatf("rr.ack0_k%0d", k), 32'(ack0), ((k / 3) % 2 == 0) ? 32'd1 : 32'd0);
        chk($sformatf("rr.ack1_k%0d", k), 32'(ack1), ((k / 3) % 2 == 1) ? 32'd1 : 32'd0);
      end else begin
        chk($sformatf("rr.noack_k%0d", k), 32'({ack1, ack0}), 32'd0);
      end
    end
    chk("rr.acc", 32'(acc), 32'h06);
    req0 = 1'b0; req1 = 1'b0;
    tick();

    // add overflow / carry
    do_clr();
    do_op("ld7f", 1'b1, 1'b0, 8'h7F);
    do_op("ovf_add", 1'b0, 1'b0, 8'h01);
    chk_res("ovf_add", 8'h80, 1'b0, 1'b1);
    do_clr();
    chk_res("clr_idle", 8'h00, 1'b0, 1'b0);
    do_op("ldff", 1'b0, 1'b0, 8'hFF);
    chk_res("ldff", 8'hFF, 1'b0, 1'b0);
    do_op("cy_add", 1'b1, 1'b0, 8'h01);
    chk_res("cy_add", 8'h00, 1'b1, 1'b0);

    // subtract borrow / overflow
    do_clr();
    do_op("brw_sub", 1'b0, 1'b1, 8'h01);
    chk_res("brw_sub", 8'hFF, 1'b1, 1'b0);
    do_clr();
    do_op("ld80", 1'b0, 1'b0, 8'h80);
    do_op("ovf_sub", 1'b1, 1'b1, 8'h01);
    chk_res("ovf_sub", 8'h7F, 1'b0, 1'b1);

    // clear during EXEC: op discarded, ack still issued once
    do_clr();
    do_op("ld10", 1'b0, 1'b0, 8'h10);
    req0 = 1'b1; sub0 = 1'b0; data0 = 8'h05;
    tick();
    clr = 1'b1;
    tick();
    clr = 1'b0; req0 = 1'b0;
    chk("clrx.ack0", 32'(ack0), 32'd1);
    chk_res("clrx", 8'h00, 1'b0, 1'b0);
    tick();
    chk("clrx.ack_once", 32'({ack1, ack0}), 32'd0);

    // clear in IDLE blocks the grant for that cycle only
    clr = 1'b1; req1 = 1'b1; sub1 = 1'b0; data1 = 8'h03;
    tick();
    clr = 1'b0;
    chk("clri.nogrant", 32'(busy), 32'd0);
    tick();
    chk("clri.grant", 32'(busy), 32'd1);
    tick();
    chk("clri.ack1", 32'({ack1, ack0}), 32'd2);
    chk("clri.acc", 32'(acc), 32'h03);
    req1 = 1'b0;
    tick();

    // reset during EXEC abandons the op and restores the tie pointer
    req0 = 1'b1; sub0 = 1'b0; data0 = 8'h07;
    tick();
    chk("arst.exec", 32'(busy), 32'd1);
    aclr = 1'b0;
    tick();
    aclr = 1'b1; req0 = 1'b0;
    chk("arst.ack", 32'({ack1, ack0}), 32'd0);
    chk("arst.busy", 32'(busy), 32'd0);
    chk_res("arst", 8'h00, 1'b0, 1'b0);
    tick();
    chk("arst.noack", 32'({ack1, ack0}), 32'd0);
    req0 = 1'b1; req1 = 1'b1; data0 = 8'h01; data1 = 8'h02; sub0 = 1'b0; sub1 = 1'b0;
    tick(); tick();
    chk("arst.tie_win0", 32'({ack1, ack0}), 32'd1);
    chk("arst.tie_acc", 32'(acc), 32'h01);
    req0 = 1'b0; req1 = 1'b0;
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/accum_rr_arbiter.md
# accum_rr_arbiter

Round-robin arbiter and sequencer that shares one N-bit add/subtract accumulator between two requesters. Each requester presents an operand and an add/sub select and holds its request until acknowledged. The block serialises operations, updates the accumulator with carry/borrow and signed-overflow flags, and returns a one-cycle acknowledge. It sits between input sources (switch/key front-ends or other controllers) and the accumulator's display/LED outputs.

## Interface
- N, 8, operand and accumulator width
- clk  input  1  system clock; all state changes on rising edge
- aclr  input  1  reset, synchronous, active-low
- req0, req1  input  1  operation request from requester 0 / 1
- sub0, sub1  input  1  operation select: 0 = add, 1 = subtract
- data0, data1  input  N  operand from requester 0 / 1
- clr  input  1  synchronous clear of accumulator and flags
- ack0, ack1  output  1  one-cycle acknowledge to requester 0 / 1
- acc  output  N  accumulator value
- carry  output  1  carry-out on add, borrow on subtract, from last executed op
- overflow  output  1  two's-complement overflow of last executed op
- busy  output  1  high whenever state is not IDLE

## Operation
- States: IDLE, EXEC, ACK. Reset state IDLE.
- IDLE: if clr=1, clear acc/carry/overflow and grant nothing this cycle. Otherwise, if any req is high, pick a winner, latch its operand, op select and ID, and go to EXEC. With no request, stay in IDLE.
- Arbitration: round-robin on a last-granted pointer. If exactly one req is high, it wins. If both are high, the one not granted last wins. Pointer resets so requester 0 wins the first tie.
- EXEC: execute the latched op, set ack of the winner, go to ACK.
  - Add: {carry, acc} <= acc + op, computed N+1 bits wide.
  - Subtract: {carry, acc} <= acc - op; carry is the MSB of the N+1-bit result, i.e. 1 on borrow.
  - Overflow on add: acc[N-1]==op[N-1] and result[N-1]!=acc[N-1].
  - Overflow on subtract: acc[N-1]!=op[N-1] and result[N-1]!=acc[N-1].
- ACK: ack of the winner is high for exactly this cycle. Go to IDLE.
- Requester rule: hold req, sub and data stable from assertion until ack is seen. At the edge ending the ack cycle, the requester either drops req or presents new data. Keeping req high issues a new request.
- clr in EXEC: clear wins. acc/carry/overflow go to 0, the op is discarded, ack is still issued. clr in ACK clears with no other effect.
- Flags change only on an executed op or a clear. Both are held otherwise.
- Reset (aclr=0 at a clock edge, any state): next cycle shows state IDLE, acc=0, carry=0, overflow=0, ack0=ack1=0, busy=0, pointer reset. An in-flight transaction is abandoned with no ack.
- ack0 and ack1 are never high together.

## Timing
- Request sampled in IDLE cycle t: acc/flags update and ack rise at the end of cycle t+1. ack is high in cycle t+2, together with the new acc. IDLE returns in cycle t+3.
- Throughput: one operation per 3 cycles. With both requesters continuously requesting, grants alternate 0,1,0,1 and acks are 3 cycles apart.
- All outputs are registered; no combinational path from inputs to outputs.
- busy is high in EXEC and ACK cycles.

## Test plan
- Reset, then req0=1, sub0=0, data0=8'h05 held until ack -> ack0 high exactly one cycle, 2 cycles after the grant cycle; acc=8'h05, carry=0, overflow=0, ack1 never high.
- acc=0, req0 and req1 held high continuously, data0=8'h01 add, data1=8'h02 add -> ack order 0,1,0,1, acks 3 cycles apart; acc=8'h06 after the 4th ack.
- acc=8'h7F, add 8'h01 -> acc=8'h80, carry=0, overflow=1. Then with acc=8'hFF, add 8'h01 -> acc=8'h00, carry=1, overflow=0.
- acc=8'h00, subtract 8'h01 -> acc=8'hFF, carry=1, overflow=0. Then with acc=8'h80, subtract 8'h01 -> acc=8'h7F, carry=0, overflow=1.
- acc=8'h10, add 8'h05 with clr=1 during the EXEC cycle -> acc=8'h00, carry=0, overflow=0, ack still pulses once. Then clr=1 in IDLE with req1 high -> no grant that cycle; req1 is granted the next cycle.
- aclr=0 for one edge while in EXEC -> no ack, acc=0, flags 0, busy=0. Afterwards both reqs high -> requester 0 is granted first.
